// File: rtl/lcd_seq_pkg.sv
// Shared constants, FSM encoding and snapshot type for lcd_frame_sequencer.
// Frame length depends on LCD_SEQ_AMPM_EN (adds " AM"/" PM").
package lcd_seq_pkg;

   localparam logic [7:0] LCD_FUNC_SET = 8'h38;
   localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_LINE1    = 8'h80;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_P     = 8'h50;
   localparam logic [7:0] ASCII_M     = 8'h4D;

   localparam int unsigned INIT_LEN = 4;
`ifdef LCD_SEQ_AMPM_EN
   localparam int unsigned FRAME_LEN = 12;
`else
   localparam int unsigned FRAME_LEN = 9;
`endif

   typedef enum logic [2:0] {
      PWRUP,
      INIT_SEND,
      INIT_GAP,
      CLR_WAIT,
      IDLE,
      FRAME_SEND,
      FRAME_GAP
   } seq_state_t;

   typedef struct packed {
      logic [7:0] hr;
      logic [7:0] mn;
      logic [7:0] sc;
      logic       pm;
   } time_snap_t;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    return LCD_FUNC_SET;
         2'd1:    return LCD_DISP_ON;
         2'd2:    return LCD_CLEAR;
         default: return LCD_ENTRY;
      endcase
   endfunction

   function automatic logic [7:0] bcd_char(input logic [3:0] n);
      return ASCII_ZERO + {4'h0, n};
   endfunction

endpackage

// File: rtl/lcd_frame_sequencer_if.sv
// Byte handshake between lcd_frame_sequencer (master) and lcd_disp_interface (slave).
interface lcd_frame_sequencer_if;
   logic [7:0] data;
   logic       ins_data;
   logic       send_data;
   logic       lcd_ready;

   modport master (output data, output ins_data, output send_data, input lcd_ready);
   modport slave  (input data, input ins_data, input send_data, output lcd_ready);
endinterface

// File: rtl/lcd_frame_rom.sv
// Combinational frame byte table: (idx, snapshot) -> {ins_data, data, last}.
// With LCD_SEQ_AMPM_EN the frame appends " AM"/" PM".
module lcd_frame_rom
   import lcd_seq_pkg::*;
(
   input  logic [3:0]  idx,
   input  time_snap_t  snap,
   output logic        ins_data,
   output logic [7:0]  data,
   output logic        last
);

`ifndef LCD_SEQ_AMPM_EN
   logic unused_pm;
   assign unused_pm = snap.pm;
`endif

   always_comb begin
      ins_data = 1'b1;
      data     = ASCII_SPACE;
      last     = (idx == 4'(FRAME_LEN - 1));
      case (idx)
         4'd0: begin
            ins_data = 1'b0;
            data     = LCD_LINE1;
         end
         4'd1: data = bcd_char(snap.hr[7:4]);
         4'd2: data = bcd_char(snap.hr[3:0]);
         4'd3: data = ASCII_COLON;
         4'd4: data = bcd_char(snap.mn[7:4]);
         4'd5: data = bcd_char(snap.mn[3:0]);
         4'd6: data = ASCII_COLON;
         4'd7: data = bcd_char(snap.sc[7:4]);
         4'd8: data = bcd_char(snap.sc[3:0]);
`ifdef LCD_SEQ_AMPM_EN
         4'd10: data = snap.pm ? ASCII_P : ASCII_A;
         4'd11: data = ASCII_M;
`endif
         default: data = ASCII_SPACE;
      endcase
   end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Sequences lcd_disp_interface: power-up wait, HD44780 init list, then "HH:MM:SS" frames.
// Optional " AM"/" PM" suffix under LCD_SEQ_AMPM_EN (handled in lcd_frame_rom).
module lcd_frame_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int unsigned POWERUP_CYC = 180000,
   parameter int unsigned CLEAR_CYC   = 24000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         refresh_req,
   input  logic [7:0]                   hr_bcd,
   input  logic [7:0]                   min_bcd,
   input  logic [7:0]                   sec_bcd,
   input  logic                         pm,
   lcd_frame_sequencer_if.master        lcd,
   output logic                         init_done,
   output logic                         frame_done
);

   seq_state_t  state;
   logic [31:0] cnt;
   logic [3:0]  idx;
   logic        pending;
   logic        last_q;
   time_snap_t  snap;

   logic        rom_ins;
   logic [7:0]  rom_data;
   logic        rom_last;

   lcd_frame_rom u_rom (
      .idx      (idx),
      .snap     (snap),
      .ins_data (rom_ins),
      .data     (rom_data),
      .last     (rom_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= PWRUP;
         cnt           <= '0;
         idx           <= '0;
         pending       <= 1'b0;
         last_q        <= 1'b0;
         snap          <= '0;
         lcd.data      <= '0;
         lcd.ins_data  <= 1'b0;
         lcd.send_data <= 1'b0;
         init_done     <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         lcd.send_data <= 1'b0;
         frame_done    <= 1'b0;
         if (refresh_req && state != IDLE)
            pending <= 1'b1;

         unique case (state)
            PWRUP: begin
               if (cnt == 32'(POWERUP_CYC - 1)) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= INIT_SEND;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            INIT_SEND: begin
               if (lcd.lcd_ready) begin
                  lcd.data      <= init_cmd(idx[1:0]);
                  lcd.ins_data  <= 1'b0;
                  lcd.send_data <= 1'b1;
                  idx           <= idx + 4'd1;
                  if (idx == 4'(INIT_LEN - 1))
                     init_done <= 1'b1;
                  state <= INIT_GAP;
               end
            end
            INIT_GAP: begin
               if (init_done) begin
                  idx   <= '0;
                  state <= IDLE;
               end else if (init_cmd(idx[1:0] - 2'd1) == LCD_CLEAR) begin
                  cnt   <= '0;
                  state <= CLR_WAIT;
               end else begin
                  state <= INIT_SEND;
               end
            end
            CLR_WAIT: begin
               if (cnt == 32'(CLEAR_CYC - 1)) begin
                  cnt   <= '0;
                  state <= INIT_SEND;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            IDLE: begin
               if (refresh_req || pending) begin
                  snap    <= {hr_bcd, min_bcd, sec_bcd, pm};
                  pending <= 1'b0;
                  // Byte 0 (set-address) does not depend on the snapshot, so it
                  // can be strobed straight from IDLE for one-cycle latency.
                  if (lcd.lcd_ready) begin
                     lcd.data      <= rom_data;
                     lcd.ins_data  <= rom_ins;
                     lcd.send_data <= 1'b1;
                     last_q        <= rom_last;
                     idx           <= idx + 4'd1;
                     state         <= FRAME_GAP;
                  end else begin
                     state <= FRAME_SEND;
                  end
               end
            end
            FRAME_SEND: begin
               if (lcd.lcd_ready) begin
                  lcd.data      <= rom_data;
                  lcd.ins_data  <= rom_ins;
                  lcd.send_data <= 1'b1;
                  last_q        <= rom_last;
                  idx           <= idx + 4'd1;
                  state         <= FRAME_GAP;
               end
            end
            FRAME_GAP: begin
               if (last_q) begin
                  frame_done <= 1'b1;
                  last_q     <= 1'b0;
                  idx        <= '0;
                  state      <= IDLE;
               end else begin
                  state <= FRAME_SEND;
               end
            end
            default: state <= PWRUP;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed self-checking bench for lcd_frame_sequencer (short power-up/clear waits).
module tb_lcd_frame_sequencer;

`ifdef LCD_SEQ_AMPM_EN
   localparam int FLEN = 12;
`else
   localparam int FLEN = 9;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       refresh_req;
   logic [7:0] hr, mn, sc;
   logic       pm;
   logic       init_done, frame_done;

   lcd_frame_sequencer_if lcd_if ();

   lcd_frame_sequencer #(
      .POWERUP_CYC (16),
      .CLEAR_CYC   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .refresh_req (refresh_req),
      .hr_bcd      (hr),
      .min_bcd     (mn),
      .sec_bcd     (sc),
      .pm          (pm),
      .lcd         (lcd_if),
      .init_done   (init_done),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [8:0] sq[$];
   int         sq_cyc[$];
   int         fd_q[$];
   bit         busy_mode = 1'b0;
   int         busy = 0;

   // Strobe monitor plus lcd_disp_interface stand-in (busy 5 cycles per byte in busy mode).
   always @(negedge clk) begin
      if (lcd_if.send_data === 1'b1) begin
         checks++;
         assert (lcd_if.lcd_ready === 1'b1) else begin
            errors++;
            $error("FAIL strobe_ready: lcd_ready=%b required 1 at cycle %0d", lcd_if.lcd_ready, cyc);
         end
         sq.push_back({lcd_if.ins_data, lcd_if.data});
         sq_cyc.push_back(cyc);
         if (busy_mode) busy = 5;
      end
      if (frame_done === 1'b1) fd_q.push_back(cyc);
      if (busy > 0) begin
         lcd_if.lcd_ready = 1'b0;
         busy--;
      end else begin
         lcd_if.lcd_ready = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ncyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_strobes(input int n, input int budget, input string tag);
      int k = 0;
      while (sq.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_timeout"}, 32'(sq.size() >= n), 32'd1);
   endtask

   task automatic pulse_req();
      refresh_req = 1'b1;
      @(negedge clk);
      refresh_req = 1'b0;
   endtask

   function automatic logic [8:0] exp_byte(input int i, input logic [7:0] h, input logic [7:0] m,
                                           input logic [7:0] s, input logic p);
      case (i)
         0:  return 9'h080;
         1:  return {1'b1, 8'h30 + {4'h0, h[7:4]}};
         2:  return {1'b1, 8'h30 + {4'h0, h[3:0]}};
         3:  return 9'h13A;
         4:  return {1'b1, 8'h30 + {4'h0, m[7:4]}};
         5:  return {1'b1, 8'h30 + {4'h0, m[3:0]}};
         6:  return 9'h13A;
         7:  return {1'b1, 8'h30 + {4'h0, s[7:4]}};
         8:  return {1'b1, 8'h30 + {4'h0, s[3:0]}};
         9:  return 9'h120;
         10: return p ? 9'h150 : 9'h141;
         default: return 9'h14D;
      endcase
   endfunction

   function automatic logic [31:0] sq_at(input int i);
      if (i < sq.size()) return {23'd0, sq[i]};
      return 32'hDEAD;
   endfunction

   task automatic check_frame(input int base, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic p, input string tag);
      for (int i = 0; i < FLEN; i++)
         chk($sformatf("%s[%0d]", tag, i), sq_at(base + i), {23'd0, exp_byte(i, h, m, s, p)});
   endtask

   task automatic check_init(input int base, input string tag);
      logic [8:0] init_exp [4];
      init_exp = '{9'h038, 9'h00C, 9'h001, 9'h006};
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s[%0d]", tag, i), sq_at(base + i), {23'd0, init_exp[i]});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_data"}, {24'd0, lcd_if.data}, 32'h00);
      chk({tag, "_ins"}, {31'd0, lcd_if.ins_data}, 32'd0);
      chk({tag, "_send"}, {31'd0, lcd_if.send_data}, 32'd0);
      chk({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
      chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, base2, rel, rq, fdn;
      rst = 1'b1; refresh_req = 1'b0;
      hr = 8'h00; mn = 8'h00; sc = 8'h00; pm = 1'b0;
      ncyc(3);
      check_reset_outputs("reset");

      // Power-up wait and init list.
      rst = 1'b0; rel = cyc;
      wait_strobes(4, 200, "init");
      ncyc(2);
      check_init(0, "init");
      chk("powerup_wait", 32'(sq_cyc[0] - rel >= 16), 32'd1);
      chk("clear_wait", 32'(sq_cyc[3] - sq_cyc[2] >= 9), 32'd1);
      chk("init_done", {31'd0, init_done}, 32'd1);
      chk("no_frame_yet", 32'(fd_q.size()), 32'd0);
      ncyc(5);

      // Basic frame, lcd_ready tied high.
      hr = 8'h12; mn = 8'h05; sc = 8'h59;
      base = sq.size(); rq = cyc;
      pulse_req();
      wait_strobes(base + FLEN, 100, "frame1");
      ncyc(4);
      check_frame(base, 8'h12, 8'h05, 8'h59, 1'b0, "frame1");
      chk("frame1_latency", 32'(sq_cyc[base] - rq), 32'd1);
      chk("frame1_count", 32'(sq.size()), 32'(base + FLEN));
      chk("frame1_done_cnt", 32'(fd_q.size()), 32'd1);
      chk("frame1_done_time", 32'(fd_q[0] - sq_cyc[base + FLEN - 1]), 32'd1);

      // Busy display: lcd_ready drops for 5 cycles after each strobe.
      busy_mode = 1'b1;
      hr = 8'h09; mn = 8'h30; sc = 8'h17;
      base = sq.size();
      pulse_req();
      wait_strobes(base + FLEN, 400, "busy");
      ncyc(10);
      check_frame(base, 8'h09, 8'h30, 8'h17, 1'b0, "busy");
      chk("busy_count", 32'(sq.size()), 32'(base + FLEN));
      chk("busy_done_cnt", 32'(fd_q.size()), 32'd2);
      busy_mode = 1'b0;
      ncyc(10);

      // Requests during a frame collapse into one follow-up frame; snapshot is stable.
      hr = 8'h12; mn = 8'h05; sc = 8'h59;
      base = sq.size();
      pulse_req();
      wait_strobes(base + 2, 50, "collapse_start");
      pulse_req();
      ncyc(1);
      pulse_req();
      sc = 8'h00;
      ncyc(1);
      pulse_req();
      wait_strobes(base + 2 * FLEN, 200, "collapse");
      ncyc(40);
      check_frame(base, 8'h12, 8'h05, 8'h59, 1'b0, "collapse_a");
      check_frame(base + FLEN, 8'h12, 8'h05, 8'h00, 1'b0, "collapse_b");
      chk("collapse_count", 32'(sq.size()), 32'(base + 2 * FLEN));
      chk("collapse_done_cnt", 32'(fd_q.size()), 32'd4);
      chk("collapse_restart", 32'(sq_cyc[base + FLEN] - fd_q[2]), 32'd1);

      // Request during power-up is held until init finishes.
      rst = 1'b1;
      ncyc(2);
      rst = 1'b0;
      ncyc(3);
      hr = 8'h07; mn = 8'h00; sc = 8'h42;
      base = sq.size(); fdn = fd_q.size();
      pulse_req();
      wait_strobes(base + 4 + FLEN, 300, "pend");
      ncyc(40);
      check_init(base, "pend_init");
      check_frame(base + 4, 8'h07, 8'h00, 8'h42, 1'b0, "pend_frame");
      chk("pend_after_init", 32'(sq_cyc[base + 4] - sq_cyc[base + 3]), 32'd2);
      chk("pend_count", 32'(sq.size()), 32'(base + 4 + FLEN));
      chk("pend_done_cnt", 32'(fd_q.size()), 32'(fdn + 1));

      // Reset in the middle of a frame.
      base = sq.size();
      pulse_req();
      wait_strobes(base + 3, 50, "abort_start");
      rst = 1'b1;
      ncyc(1);
      check_reset_outputs("abort");
      ncyc(1);
      rst = 1'b0; rel = cyc;
      base2 = sq.size();
      wait_strobes(base2 + 4, 200, "reinit");
      ncyc(60);
      check_init(base2, "reinit");
      chk("reinit_wait", 32'(sq_cyc[base2] - rel >= 16), 32'd1);
      chk("reinit_no_frame", 32'(sq.size()), 32'(base2 + 4));

      // pm handling.
      pm = 1'b1; hr = 8'h11; mn = 8'h59; sc = 8'h30;
      base = sq.size();
      pulse_req();
      wait_strobes(base + FLEN, 100, "pm1");
      ncyc(30);
      check_frame(base, 8'h11, 8'h59, 8'h30, 1'b1, "pm1");
      chk("pm1_count", 32'(sq.size()), 32'(base + FLEN));
`ifdef LCD_SEQ_AMPM_EN
      chk("pm1_tail0", sq_at(base + 9), 32'h120);
      chk("pm1_tail1", sq_at(base + 10), 32'h150);
      chk("pm1_tail2", sq_at(base + 11), 32'h14D);
      pm = 1'b0;
      base = sq.size();
      pulse_req();
      wait_strobes(base + FLEN, 100, "pm0");
      ncyc(30);
      chk("pm0_tail0", sq_at(base + 9), 32'h120);
      chk("pm0_tail1", sq_at(base + 10), 32'h141);
      chk("pm0_tail2", sq_at(base + 11), 32'h14D);
      chk("pm0_count", 32'(sq.size()), 32'(base + 12));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_frame_sequencer.md
Name: lcd_frame_sequencer

Overview:
Controller that sequences lcd_disp_interface for the digital clock.
- After reset: waits out LCD power-up, then issues the HD44780 init command list.
- On each refresh request: snapshots the BCD time and writes it to line 1 as "HH:MM:SS", optionally followed by " AM"/" PM".
- Sits between the time-keeping counters and lcd_disp_interface, and is the only driver of that interface's data/ins_data/send_data.

Parameters:
POWERUP_CYC, 180000, clk cycles waited after reset before the first command (15 ms at 12 MHz).
CLEAR_CYC, 24000, extra clk cycles waited after the clear-display command (2 ms at 12 MHz).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
refresh_req  in  1  one-cycle pulse requesting a frame redraw
hr_bcd  in  8  hours, two BCD digits {tens, units}
min_bcd  in  8  minutes, BCD
sec_bcd  in  8  seconds, BCD
pm  in  1  1 = PM (used only with AMPM_EN)
lcd_ready  in  1  high when lcd_disp_interface can accept a byte
data  out  8  byte to lcd_disp_interface
ins_data  out  1  0 = instruction byte, 1 = character byte
send_data  out  1  one-cycle strobe; data/ins_data are valid in the same cycle
init_done  out  1  level; high once the init list has completed
frame_done  out  1  one-cycle pulse after the last byte of a frame is sent

Behaviour:
- Reset values: data=0x00, ins_data=0, send_data=0, init_done=0, frame_done=0. State=PWRUP, wait counter=0, pending flag clear.
- Reset mid-operation: abandons everything and restarts from PWRUP on the next edge.
- Handshake:
  - send_data pulses for exactly one cycle, and only in a cycle where lcd_ready=1.
  - After a strobe, the FSM ignores lcd_ready for one cycle (gap state), then waits for lcd_ready=1 again.
  - data and ins_data hold their value until the next strobe.
- FSM states: PWRUP, INIT_SEND, INIT_GAP, CLR_WAIT, IDLE, FRAME_SEND, FRAME_GAP.
- PWRUP: counts POWERUP_CYC cycles, then goes to INIT_SEND with idx=0.
- INIT_SEND: sends instructions in order: 0x38 (function set), 0x0C (display on), 0x01 (clear), 0x06 (entry mode).
  - After 0x01, enters CLR_WAIT for CLEAR_CYC cycles before sending 0x06.
  - After 0x06 is strobed: init_done=1 (stays high until rst), go to IDLE.
- refresh_req seen in any state before IDLE sets the pending flag; the frame starts on entering IDLE.
- IDLE: if refresh_req or pending is set:
  - latch hr/min/sec/pm into a snapshot;
  - clear pending;
  - go to FRAME_SEND with idx=0.
- Frame byte list:
  - idx0: instruction 0x80 (DDRAM address 0);
  - then characters: H tens, H units, ':', M tens, M units, ':', S tens, S units.
  - Digit character = 0x30 + BCD nibble. ':' = 0x3A.
  - Frame length is 9 bytes, or 12 with AMPM_EN.
- Digits are taken from the snapshot only; input changes mid-frame have no effect on the frame in progress.
- Non-BCD nibbles (>9) are not checked; they map to 0x30+nibble.
- refresh_req during a frame sets pending. Multiple requests collapse into one. The next frame starts from IDLE 1 cycle after frame_done.
- frame_done pulses in the cycle after the last strobe. refresh_req in that same cycle is honoured, not lost.
- Latency: refresh_req in IDLE with lcd_ready=1 → first send_data 1 cycle later.

Optional Feature:
Macro LCD_SEQ_AMPM_EN.
- Defined: frame appends ' '(0x20), then 'P'(0x50) or 'A'(0x41) from the snapshot pm, then 'M'(0x4D). Frame is 12 bytes.
- Undefined: pm is unused, frame is 9 bytes, and no character is written past column 7.

Decomposition:
Package lcd_seq_pkg holds:
- command constants LCD_FUNC_SET=0x38, LCD_DISP_ON=0x0C, LCD_CLEAR=0x01, LCD_ENTRY=0x06, LCD_LINE1=0x80;
- ASCII_ZERO=0x30, ASCII_COLON=0x3A;
- the FSM state encoding;
- INIT_LEN=4.

Sub-module lcd_frame_rom: combinational; (idx, snapshot) → {ins_data, data, last}. The sequencer owns timing and handshake only.

Test Plan:
1. POWERUP_CYC=16, CLEAR_CYC=8, lcd_ready tied 1, rst pulse → first strobe ≥16 cycles after reset; strobes carry 0x38, 0x0C, 0x01 (ins_data=0); ≥8 cycles, then 0x06; init_done rises.
2. After init, hr=0x12, min=0x05, sec=0x59, refresh_req pulse → strobes 0x80(ins), then 0x31 0x32 0x3A 0x30 0x35 0x3A 0x35 0x39 (ins_data=1); frame_done one pulse.
3. lcd_ready toggled low 5 cycles after every strobe → same byte sequence, no strobe while lcd_ready=0, exactly one strobe per byte.
4. Three refresh_req pulses during a frame, sec changed 0x59→0x00 mid-frame → current frame shows "59"; exactly one more frame follows, showing "00".
5. refresh_req before init_done → held pending; one frame emitted right after the 0x06 strobe; rst asserted mid-frame → outputs return to reset values and the init list restarts.
6. With LCD_SEQ_AMPM_EN, pm=1 → 12 strobes ending 0x20 0x50 0x4D; pm=0 → ending 0x20 0x41 0x4D.
